// File: rtl/jpeg_packetizer_if.sv
// Byte-stream bundle: encoder-side input strobe plus the valid/ready packet
// stream towards the Ethernet bridge. The packetizer uses the slave view.
interface jpeg_packetizer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_start;
    logic       out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_start, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_start, out_last
    );
endinterface

// File: rtl/jpeg_packetizer.sv
// Buffers an MJPEG byte stream, splits each EOI-terminated frame into packets
// of at most PAYLOAD_BYTES and prefixes every packet with an 8-byte header.
module jpeg_packetizer #(
    parameter int unsigned PAYLOAD_BYTES = 1024,
    parameter int unsigned FIFO_AW       = 12,
    parameter int unsigned LEN_AW        = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    jpeg_packetizer_if.slave bus,
    output logic             overflow,
    output logic [15:0]      frame_id
);
    localparam int unsigned DEPTH     = 1 << FIFO_AW;
    localparam int unsigned LEN_DEPTH = 1 << LEN_AW;
    localparam logic [23:0] PAY_LEN   = 24'(PAYLOAD_BYTES);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
    state_t state, state_nxt;

    // byte FIFO (first-word fall-through)
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, wr_en, rd_en;

    // frame-length FIFO
    logic [23:0]        len_mem [LEN_DEPTH];
    logic [LEN_AW-1:0]  len_wr_ptr, len_rd_ptr;
    logic [LEN_AW:0]    len_count;
    logic               len_full, len_vld, len_push, len_pop;

    logic [23:0]        wr_frame_len, rd_consumed, rem;
    logic               prev_ff, eoi;
    logic [7:0]         seq;
    logic [2:0]         hdr_idx;
    logic [15:0]        pay_cnt, pkt_len_q, pkt_len_nxt;
    logic               first_q, last_q, last_nxt;
    logic               start, pkt_done, pay_last;
    logic [7:0]         hdr_byte;

    assign full     = count[FIFO_AW];
    assign len_full = len_count[LEN_AW];
    assign len_vld  = (len_count != '0);
    assign wr_en    = bus.in_valid && !full;
    assign eoi      = wr_en && prev_ff && (bus.in_data == 8'hD9);
    assign len_push = eoi && !len_full;
    assign len_pop  = pkt_done && last_q;

    // Without a queued length the remaining frame size is unbounded.
    assign rem         = len_mem[len_rd_ptr] - rd_consumed;
    assign last_nxt    = len_vld && (rem <= PAY_LEN);
    assign pkt_len_nxt = last_nxt ? rem[15:0] : PAY_LEN[15:0];
    assign start       = len_vld || (32'(count) >= PAYLOAD_BYTES);
    assign pay_last    = (pay_cnt == pkt_len_q - 16'd1);

    always_comb begin
        case (hdr_idx)
            3'd0:    hdr_byte = 8'h4A;
            3'd1:    hdr_byte = 8'h50;
            3'd2:    hdr_byte = frame_id[15:8];
            3'd3:    hdr_byte = frame_id[7:0];
            3'd4:    hdr_byte = seq;
            3'd5:    hdr_byte = {6'b0, last_q, first_q};
            3'd6:    hdr_byte = pkt_len_q[15:8];
            default: hdr_byte = pkt_len_q[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_start = 1'b0;
        bus.out_last  = 1'b0;
        rd_en         = 1'b0;
        pkt_done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = HDR;
            end
            HDR: begin
                bus.out_valid = 1'b1;
                bus.out_data  = hdr_byte;
                bus.out_start = (hdr_idx == 3'd0);
                if (bus.out_ready && hdr_idx == 3'd7) state_nxt = PAY;
            end
            PAY: begin
                bus.out_valid = 1'b1;
                bus.out_data  = mem[rd_ptr];
                bus.out_last  = pay_last;
                if (bus.out_ready) begin
                    rd_en = 1'b1;
                    if (pay_last) begin
                        pkt_done  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (len_push) len_mem[len_wr_ptr] <= wr_frame_len + 24'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            len_wr_ptr   <= '0;
            len_rd_ptr   <= '0;
            len_count    <= '0;
            wr_frame_len <= '0;
            prev_ff      <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            // full is judged on the pre-read count, so a same-cycle read does not save the byte
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(rd_en);

            if (len_push) len_wr_ptr <= len_wr_ptr + 1'b1;
            if (len_pop)  len_rd_ptr <= len_rd_ptr + 1'b1;
            len_count <= len_count + (LEN_AW+1)'(len_push) - (LEN_AW+1)'(len_pop);

            // an EOI with no room in the length FIFO merges this frame into the next
            if (len_push)   wr_frame_len <= '0;
            else if (wr_en) wr_frame_len <= wr_frame_len + 24'd1;

            if (wr_en) prev_ff <= (bus.in_data == 8'hFF);
            if ((bus.in_valid && full) || (eoi && len_full)) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_idx     <= '0;
            pay_cnt     <= '0;
            pkt_len_q   <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            seq         <= '0;
            frame_id    <= '0;
            rd_consumed <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pkt_len_q <= pkt_len_nxt;
                        first_q   <= (rd_consumed == '0);
                        last_q    <= last_nxt;
                        hdr_idx   <= '0;
                        pay_cnt   <= '0;
                    end
                end
                HDR:     if (bus.out_ready) hdr_idx <= hdr_idx + 3'd1;
                PAY:     if (rd_en) pay_cnt <= pay_cnt + 16'd1;
                default: ;
            endcase
            if (pkt_done) begin
                if (last_q) begin
                    rd_consumed <= '0;
                    seq         <= '0;
                    frame_id    <= frame_id + 16'd1;
                end else begin
                    rd_consumed <= rd_consumed + 24'(pkt_len_q);
                    seq         <= seq + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_jpeg_packetizer.sv
// Directed bench for jpeg_packetizer: default instance for framing/packetizing,
// a tiny instance (FIFO_AW=4, PAYLOAD_BYTES=16) for the overflow path.
`timescale 1ns/1ps
module tb_jpeg_packetizer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jpeg_packetizer_if bus ();
    jpeg_packetizer_if bus_s ();
    logic        overflow, overflow_s;
    logic [15:0] frame_id, frame_id_s;

    jpeg_packetizer dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .overflow(overflow), .frame_id(frame_id)
    );
    jpeg_packetizer #(.PAYLOAD_BYTES(16), .FIFO_AW(4), .LEN_AW(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s), .overflow(overflow_s), .frame_id(frame_id_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] frm[$], drv[$];
    logic [7:0] exp_d[$], got_d[$], sg_d[$];
    bit         exp_s[$], exp_l[$], got_s[$], got_l[$], sg_s[$], sg_l[$];
    int         start_sent[$];
    int         sent_cnt   = 0;
    int         stall_viol = 0;
    bit         abort      = 1'b0;

    // output capture (main instance) with stall-stability tally
    bit         prev_stall = 1'b0;
    logic [7:0] pd;
    logic       ps, pl;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== pd ||
                               bus.out_start !== ps || bus.out_last !== pl))
                stall_viol++;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                got_d.push_back(bus.out_data);
                got_s.push_back(bus.out_start);
                got_l.push_back(bus.out_last);
                if (bus.out_start === 1'b1) start_sent.push_back(sent_cnt);
            end
            prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            pd = bus.out_data;
            ps = bus.out_start;
            pl = bus.out_last;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_s.out_valid === 1'b1 && bus_s.out_ready === 1'b1) begin
            sg_d.push_back(bus_s.out_data);
            sg_s.push_back(bus_s.out_start);
            sg_l.push_back(bus_s.out_last);
        end
    end

    task automatic clear_all();
        got_d.delete(); got_s.delete(); got_l.delete();
        exp_d.delete(); exp_s.delete(); exp_l.delete();
        start_sent.delete(); drv.delete();
        sent_cnt = 0; stall_viol = 0;
    endtask

    task automatic make_frame(input int len, input int seed);
        frm.delete();
        frm.push_back(8'hFF);
        frm.push_back(8'hD8);
        for (int i = 2; i < len - 2; i++) frm.push_back(8'((i * 7 + seed) % 255));
        frm.push_back(8'hFF);
        frm.push_back(8'hD9);
        foreach (frm[i]) drv.push_back(frm[i]);
    endtask

    task automatic push_exp(input logic [7:0] d, input bit s, input bit l);
        exp_d.push_back(d); exp_s.push_back(s); exp_l.push_back(l);
    endtask

    // reference split of the frame in frm into header + payload packets
    task automatic model(input logic [15:0] fid, input int pay);
        int off;
        int n;
        int len;
        logic [7:0] sq;
        off = 0; sq = 8'd0; len = frm.size();
        while (off < len) begin
            n = (len - off < pay) ? len - off : pay;
            push_exp(8'h4A, 1'b1, 1'b0);
            push_exp(8'h50, 1'b0, 1'b0);
            push_exp(fid[15:8], 1'b0, 1'b0);
            push_exp(fid[7:0], 1'b0, 1'b0);
            push_exp(sq, 1'b0, 1'b0);
            push_exp({6'b0, (off + n == len), (off == 0)}, 1'b0, 1'b0);
            push_exp(8'(n >> 8), 1'b0, 1'b0);
            push_exp(8'(n), 1'b0, 1'b0);
            for (int k = 0; k < n; k++) push_exp(frm[off + k], 1'b0, (k == n - 1));
            off += n;
            sq  += 8'd1;
        end
    endtask

    task automatic drive_frm();
        for (int i = 0; i < drv.size(); i++) begin
            @(posedge clk); #1;
            if (abort) begin
                bus.in_valid = 1'b0;
                break;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = drv[i];
            sent_cnt++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget);
        for (int c = 0; c < budget && got_d.size() < n; c++) @(negedge clk);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data got %h exp 00", bus.out_data); end
        n_checks++; if ({bus.out_start, bus.out_last} !== 2'b00) begin n_fail++; $display("FAIL rst_start_last got %b exp 00", {bus.out_start, bus.out_last}); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b exp 0", overflow); end
        n_checks++; if (frame_id !== 16'h0000) begin n_fail++; $display("FAIL rst_frame_id got %h exp 0000", frame_id); end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_single_packet();
        clear_all();
        bus.out_ready = 1'b1;
        make_frame(10, 3);
        model(16'd0, 1024);
        drive_frm();
        wait_got(18, 200);
        n_checks++; if (got_d.size() !== 18) begin n_fail++; $display("FAIL single_len got %0d exp 18", got_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_checks++;
            if ({got_d[i], got_s[i], got_l[i]} !== {exp_d[i], exp_s[i], exp_l[i]}) begin
                n_fail++; $display("FAIL single_byte[%0d] got %h/%b/%b exp %h/%b/%b", i, got_d[i], got_s[i], got_l[i], exp_d[i], exp_s[i], exp_l[i]); break;
            end
        end
        if (got_d.size() == 18) begin
            n_checks++; if ({got_d[5], got_d[6], got_d[7]} !== 24'h03000A) begin n_fail++; $display("FAIL single_flags_len got %h%h%h exp 03000A", got_d[5], got_d[6], got_d[7]); end
            n_checks++; if ({got_s[0], got_l[17]} !== 2'b11) begin n_fail++; $display("FAIL single_start_last got %b exp 11", {got_s[0], got_l[17]}); end
        end
        n_checks++; if (frame_id !== 16'd1) begin n_fail++; $display("FAIL single_frame_id got %0d exp 1", frame_id); end
    endtask

    task automatic test_multi_packet();
        clear_all();
        bus.out_ready = 1'b1;
        make_frame(2500, 5);
        model(16'd1, 1024);
        drive_frm();
        wait_got(2524, 8000);
        n_checks++; if (got_d.size() !== 2524) begin n_fail++; $display("FAIL multi_len got %0d exp 2524", got_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_checks++;
            if ({got_d[i], got_s[i], got_l[i]} !== {exp_d[i], exp_s[i], exp_l[i]}) begin
                n_fail++; $display("FAIL multi_byte[%0d] got %h/%b/%b exp %h/%b/%b", i, got_d[i], got_s[i], got_l[i], exp_d[i], exp_s[i], exp_l[i]); break;
            end
        end
        if (got_d.size() == 2524) begin
            n_checks++; if ({got_d[4], got_d[1036], got_d[2068]} !== 24'h000102) begin n_fail++; $display("FAIL multi_seq got %h %h %h exp 00 01 02", got_d[4], got_d[1036], got_d[2068]); end
            n_checks++; if ({got_d[5], got_d[1037], got_d[2069]} !== 24'h010002) begin n_fail++; $display("FAIL multi_flags got %h %h %h exp 01 00 02", got_d[5], got_d[1037], got_d[2069]); end
            n_checks++; if ({got_d[6], got_d[7], got_d[1038], got_d[1039], got_d[2070], got_d[2071]} !== 48'h0400_0400_01C4) begin
                n_fail++; $display("FAIL multi_lens got %h%h %h%h %h%h exp 0400 0400 01C4", got_d[6], got_d[7], got_d[1038], got_d[1039], got_d[2070], got_d[2071]);
            end
        end
        n_checks++; if (frame_id !== 16'd2) begin n_fail++; $display("FAIL multi_frame_id got %0d exp 2", frame_id); end
    endtask

    task automatic test_early_start();
        clear_all();
        bus.out_ready = 1'b1;
        make_frame(5000, 17);
        model(16'd2, 1024);
        drive_frm();
        wait_got(5040, 12000);
        n_checks++; if (got_d.size() !== 5040) begin n_fail++; $display("FAIL early_len got %0d exp 5040", got_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_checks++;
            if ({got_d[i], got_s[i], got_l[i]} !== {exp_d[i], exp_s[i], exp_l[i]}) begin
                n_fail++; $display("FAIL early_byte[%0d] got %h/%b/%b exp %h/%b/%b", i, got_d[i], got_s[i], got_l[i], exp_d[i], exp_s[i], exp_l[i]); break;
            end
        end
        n_checks++;
        if (start_sent.size() == 0 || start_sent[0] < 1024 || start_sent[0] > 1030) begin
            n_fail++; $display("FAIL early_first_start got %0d bytes sent exp 1024..1030", (start_sent.size() == 0) ? -1 : start_sent[0]);
        end
        if (got_d.size() == 5040) begin
            n_checks++; if (got_d[5] !== 8'h01) begin n_fail++; $display("FAIL early_first_flags got %h exp 01", got_d[5]); end
            n_checks++; if ({got_d[4133], got_d[4134], got_d[4135]} !== 24'h020388) begin n_fail++; $display("FAIL early_last_hdr got %h %h%h exp 02 0388", got_d[4133], got_d[4134], got_d[4135]); end
        end
        n_checks++; if (frame_id !== 16'd3) begin n_fail++; $display("FAIL early_frame_id got %0d exp 3", frame_id); end
    endtask

    task automatic test_random_ready();
        clear_all();
        make_frame(300, 21);  model(16'd3, 1024);
        make_frame(1500, 33); model(16'd4, 1024);
        make_frame(40, 47);   model(16'd5, 1024);
        fork
            drive_frm();
            begin : rdy
                int cyc;
                cyc = 0;
                while (got_d.size() < exp_d.size() && cyc < 20000) begin
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                    cyc++;
                end
                bus.out_ready = 1'b1;
            end
        join
        repeat (5) @(negedge clk);
        n_checks++; if (got_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL rand_len got %0d exp %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_checks++;
            if ({got_d[i], got_s[i], got_l[i]} !== {exp_d[i], exp_s[i], exp_l[i]}) begin
                n_fail++; $display("FAIL rand_byte[%0d] got %h/%b/%b exp %h/%b/%b", i, got_d[i], got_s[i], got_l[i], exp_d[i], exp_s[i], exp_l[i]); break;
            end
        end
        n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL rand_stall_stable got %0d changes exp 0", stall_viol); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rand_overflow got %b exp 0", overflow); end
        n_checks++; if (frame_id !== 16'd6) begin n_fail++; $display("FAIL rand_frame_id got %0d exp 6", frame_id); end
    endtask

    task automatic test_overflow();
        logic [7:0] hdr [8];
        hdr = '{8'h4A, 8'h50, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h10};
        @(posedge clk); #1; rst_n = 1'b0;
        bus_s.out_ready = 1'b0;
        repeat (2) @(posedge clk); #1; rst_n = 1'b1;
        sg_d.delete(); sg_s.delete(); sg_l.delete();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 16) begin
                n_checks++; if (overflow_s !== 1'b0) begin n_fail++; $display("FAIL ovf_after_16 got %b exp 0", overflow_s); end
            end
            if (i == 17) begin
                n_checks++; if (overflow_s !== 1'b1) begin n_fail++; $display("FAIL ovf_after_17 got %b exp 1", overflow_s); end
            end
            bus_s.in_valid = 1'b1;
            bus_s.in_data  = 8'(16 + i);
        end
        @(posedge clk); #1;
        bus_s.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus_s.out_ready = 1'b1;
        for (int c = 0; c < 200 && sg_d.size() < 24; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_checks++; if (sg_d.size() !== 24) begin n_fail++; $display("FAIL ovf_pkt_len got %0d exp 24", sg_d.size()); end
        if (sg_d.size() == 24) begin
            for (int i = 0; i < 24; i++) begin
                n_checks++;
                if (sg_d[i] !== ((i < 8) ? hdr[i] : 8'(16 + i - 8))) begin
                    n_fail++; $display("FAIL ovf_byte[%0d] got %h exp %h", i, sg_d[i], (i < 8) ? hdr[i] : 8'(16 + i - 8)); break;
                end
            end
            n_checks++; if ({sg_s[0], sg_l[23], sg_l[22]} !== 3'b110) begin n_fail++; $display("FAIL ovf_start_last got %b exp 110", {sg_s[0], sg_l[23], sg_l[22]}); end
        end
        n_checks++; if (overflow_s !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow_s); end
        n_checks++; if (frame_id_s !== 16'd0) begin n_fail++; $display("FAIL ovf_frame_id got %0d exp 0", frame_id_s); end
    endtask

    task automatic test_reset_mid();
        clear_all();
        bus.out_ready = 1'b1;
        make_frame(10, 7);
        drive_frm();
        wait_got(18, 200);
        n_checks++; if (frame_id !== 16'd1) begin n_fail++; $display("FAIL mid_pre_frame_id got %0d exp 1", frame_id); end
        clear_all();
        make_frame(2000, 9);
        abort = 1'b0;
        fork
            drive_frm();
            begin
                for (int c = 0; c < 3000 && got_d.size() < 20; c++) @(negedge clk);
                @(posedge clk); #2;
                n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b exp 1", bus.out_valid); end
                rst_n = 1'b0;
                abort = 1'b1;
                #1;
                n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid got %b exp 0", bus.out_valid); end
                n_checks++; if (overflow_s !== 1'b0) begin n_fail++; $display("FAIL mid_async_overflow got %b exp 0", overflow_s); end
                n_checks++; if (frame_id !== 16'd0) begin n_fail++; $display("FAIL mid_async_frame_id got %0d exp 0", frame_id); end
                repeat (3) @(posedge clk); #1;
                rst_n = 1'b1;
            end
        join
        abort = 1'b0;
        clear_all();
        make_frame(10, 11);
        model(16'd0, 1024);
        drive_frm();
        wait_got(18, 200);
        n_checks++; if (got_d.size() !== 18) begin n_fail++; $display("FAIL post_rst_len got %0d exp 18", got_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_checks++;
            if ({got_d[i], got_s[i], got_l[i]} !== {exp_d[i], exp_s[i], exp_l[i]}) begin
                n_fail++; $display("FAIL post_rst_byte[%0d] got %h/%b/%b exp %h/%b/%b", i, got_d[i], got_s[i], got_l[i], exp_d[i], exp_s[i], exp_l[i]); break;
            end
        end
        if (got_d.size() == 18) begin
            n_checks++; if ({got_d[4], got_d[5]} !== 16'h0003) begin n_fail++; $display("FAIL post_rst_seq_flags got %h %h exp 00 03", got_d[4], got_d[5]); end
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = 8'h00;
        bus.out_ready   = 1'b0;
        bus_s.in_valid  = 1'b0;
        bus_s.in_data   = 8'h00;
        bus_s.out_ready = 1'b0;
        test_reset();
        test_single_packet();
        test_multi_packet();
        test_early_start();
        test_random_ready();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
